// File: rtl/uart_rx_ext.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_rx_ext : parametrised oversampling UART receiver with 3-sample vote,  |
// |               error/break/overrun flags and a one-entry valid/ready output. |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module uart_rx_ext #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 baud_xn,
  input  logic                 serial,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  input  logic                 ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 break_det,
  output logic                 overrun,
  output logic                 busy
);

  localparam int c_PW = $clog2(OVERSAMPLE);
  localparam int c_BW = $clog2(DATA_BITS);
  localparam logic [c_PW-1:0] c_SMP0 = c_PW'(OVERSAMPLE/2 - 1);
  localparam logic [c_PW-1:0] c_MID  = c_PW'(OVERSAMPLE/2);
  localparam logic [c_PW-1:0] c_DEC  = c_PW'(OVERSAMPLE/2 + 1);
  localparam logic [c_PW-1:0] c_LAST = c_PW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_DATA    = 3'd2,
    S_PARITY  = 3'd3,
    S_STOP    = 3'd4,
    S_BRKWAIT = 3'd5
  } state_t;

  state_t                 state_q;
  logic                   sync1_q, sync2_q;
  logic [c_PW-1:0]        ph_q;
  logic [c_BW-1:0]        bit_q;
  logic [1:0]             smp_q;
  logic [DATA_BITS-1:0]   shift_q;
  logic                   par_q;
  logic                   stop_any0_q, stop_all0_q;
  logic [DATA_BITS-1:0]   data_q;
  logic                   valid_q;
  logic                   frame_err_q, parity_err_q, break_q, overrun_q;

  logic w_line, w_vote, w_dec, w_last_stop, w_any0, w_all0;
  logic w_xor, w_par_bad, w_brk, w_commit, w_good, w_take;

  assign w_line      = sync2_q;
  assign w_vote      = (smp_q[0] & smp_q[1]) | (smp_q[0] & w_line) | (smp_q[1] & w_line);
  assign w_dec       = baud_xn && (ph_q == c_DEC);
  assign w_last_stop = (bit_q == c_BW'(STOP_BITS - 1));
  // Stop-bit history folded with the decision being made this tick.
  assign w_any0      = stop_any0_q | ~w_vote;
  assign w_all0      = stop_all0_q & ~w_vote;
  assign w_xor       = (^shift_q) ^ par_q;
  assign w_par_bad   = (PARITY == 1) ? w_xor : (PARITY == 2) ? ~w_xor : 1'b0;
  assign w_brk       = (shift_q == '0) && ((PARITY == 0) || !par_q) && w_all0;
  assign w_commit    = w_dec && (state_q == S_STOP) && w_last_stop;
  assign w_good      = w_commit && !w_brk && !w_any0 && !w_par_bad;
  assign w_take      = w_good && (!valid_q || ready);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      ph_q         <= '0;
      bit_q        <= '0;
      smp_q        <= '0;
      shift_q      <= '0;
      par_q        <= 1'b0;
      stop_any0_q  <= 1'b0;
      stop_all0_q  <= 1'b1;
      data_q       <= '0;
      valid_q      <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      break_q      <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      sync1_q      <= serial;
      sync2_q      <= sync1_q;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      break_q      <= 1'b0;
      overrun_q    <= 1'b0;

      if (baud_xn) begin
        ph_q <= (ph_q == c_LAST) ? '0 : ph_q + c_PW'(1);
        if (ph_q == c_SMP0) smp_q[0] <= w_line;
        if (ph_q == c_MID)  smp_q[1] <= w_line;
        case (state_q)
          S_IDLE: begin
            if (!w_line) begin
              state_q     <= S_START;
              ph_q        <= c_PW'(1);
              stop_any0_q <= 1'b0;
              stop_all0_q <= 1'b1;
            end else begin
              ph_q <= '0;
            end
          end
          S_START: begin
            if (w_dec && w_vote) begin
              state_q <= S_IDLE;
              ph_q    <= '0;
            end else if (ph_q == c_LAST) begin
              state_q <= S_DATA;
              bit_q   <= '0;
            end
          end
          S_DATA: begin
            if (w_dec) shift_q <= {w_vote, shift_q[DATA_BITS-1:1]};
            if (ph_q == c_LAST) begin
              if (bit_q == c_BW'(DATA_BITS - 1)) begin
                bit_q   <= '0;
                state_q <= (PARITY != 0) ? S_PARITY : S_STOP;
              end else begin
                bit_q <= bit_q + c_BW'(1);
              end
            end
          end
          S_PARITY: begin
            if (w_dec) par_q <= w_vote;
            if (ph_q == c_LAST) state_q <= S_STOP;
          end
          S_STOP: begin
            if (w_dec) begin
              if (w_last_stop) begin
                ph_q <= '0;
                if (w_brk) begin
                  state_q <= S_BRKWAIT;
                  break_q <= 1'b1;
                end else begin
                  state_q      <= S_IDLE;
                  frame_err_q  <= w_any0;
                  parity_err_q <= w_par_bad;
                end
              end else begin
                stop_any0_q <= w_any0;
                stop_all0_q <= w_all0;
              end
            end
            if ((ph_q == c_LAST) && !w_last_stop) bit_q <= bit_q + c_BW'(1);
          end
          S_BRKWAIT: begin
            ph_q <= '0;
            if (w_line) state_q <= S_IDLE;
          end
          default: begin
            state_q <= S_IDLE;
            ph_q    <= '0;
          end
        endcase
      end

      // A commit landing on a draining cycle reloads the register, so valid stays high.
      if (w_take) begin
        data_q  <= shift_q;
        valid_q <= 1'b1;
      end else if (valid_q && ready) begin
        valid_q <= 1'b0;
      end
      if (w_good && !w_take) overrun_q <= 1'b1;
    end
  end

  assign data       = data_q;
  assign valid      = valid_q;
  assign frame_err  = frame_err_q;
  assign parity_err = parity_err_q;
  assign break_det  = break_q;
  assign overrun    = overrun_q;
  assign busy       = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_ext.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_uart_rx_ext : scoreboard bench for uart_rx_ext in three configurations. |
// | Revision       : 1.0                                                       |
// +----------------------------------------------------------------------------+
module tb_uart_rx_ext;

  localparam logic [2:0] K_DATA = 3'd0;
  localparam logic [2:0] K_FRM  = 3'd1;
  localparam logic [2:0] K_PAR  = 3'd2;
  localparam logic [2:0] K_BRK  = 3'd3;
  localparam logic [2:0] K_OVR  = 3'd4;

  typedef struct packed {
    logic [2:0] kind;
    logic [8:0] data;
  } exp_t;

  logic clk, reset, baud_xn;
  logic ser [3];
  logic rdy [3];

  logic [7:0] da, db;
  logic [6:0] dc;
  logic va, vb, vc, fea, feb, fec, pea, peb, pec, bka, bkb, bkc, ova, ovb, ovc, bsa, bsb, bsc;

  exp_t q0[$], q1[$], q2[$];
  int total, bad;

  // A: 8-N-1 x4, B: 8-E-1 x16, C: 7-O-2 x4
  uart_rx_ext u_a (
    .clk(clk), .reset(reset), .baud_xn(baud_xn), .serial(ser[0]), .data(da), .valid(va),
    .ready(rdy[0]), .frame_err(fea), .parity_err(pea), .break_det(bka), .overrun(ova), .busy(bsa)
  );
  uart_rx_ext #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .OVERSAMPLE(16)) u_b (
    .clk(clk), .reset(reset), .baud_xn(baud_xn), .serial(ser[1]), .data(db), .valid(vb),
    .ready(rdy[1]), .frame_err(feb), .parity_err(peb), .break_det(bkb), .overrun(ovb), .busy(bsb)
  );
  uart_rx_ext #(.DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .OVERSAMPLE(4)) u_c (
    .clk(clk), .reset(reset), .baud_xn(baud_xn), .serial(ser[2]), .data(dc), .valid(vc),
    .ready(rdy[2]), .frame_err(fec), .parity_err(pec), .break_det(bkc), .overrun(ovc), .busy(bsc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_ev(input int k, input logic [2:0] kind, input logic [8:0] d);
    exp_t e;
    e.kind = kind;
    e.data = d;
    case (k)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic pop_cmp(input int k, input logic [2:0] kind, input logic [8:0] d);
    exp_t e;
    int   sz;
    sz = (k == 0) ? q0.size() : (k == 1) ? q1.size() : q2.size();
    total++;
    if (sz == 0) begin
      bad++;
      $display("FAIL event inst=%0d: got kind=%0d data=%h expected none", k, kind, d);
    end else begin
      case (k)
        0:       e = q0.pop_front();
        1:       e = q1.pop_front();
        default: e = q2.pop_front();
      endcase
      if (e.kind !== kind || e.data !== d) begin
        bad++;
        $display("FAIL event inst=%0d: got kind=%0d data=%h expected kind=%0d data=%h",
                 k, kind, d, e.kind, e.data);
      end
    end
  endtask

  task automatic mon(input int k, input logic v, input logic r, input logic [8:0] d,
                     input logic fe, input logic pe, input logic bk, input logic ov);
    if (fe)     pop_cmp(k, K_FRM, 9'h0);
    if (pe)     pop_cmp(k, K_PAR, 9'h0);
    if (bk)     pop_cmp(k, K_BRK, 9'h0);
    if (ov)     pop_cmp(k, K_OVR, 9'h0);
    if (v && r) pop_cmp(k, K_DATA, d);
  endtask

  always @(negedge clk) begin
    #2;
    if (!reset) begin
      mon(0, va, rdy[0], {1'b0, da}, fea, pea, bka, ova);
      mon(1, vb, rdy[1], {1'b0, db}, feb, peb, bkb, ovb);
      mon(2, vc, rdy[2], {2'b0, dc}, fec, pec, bkc, ovc);
    end
  end

  // One baud tick per slot; the value set at slot start reaches serial_sync before the tick.
  task automatic slot(input int k, input logic v);
    ser[k] = v;
    repeat (3) @(negedge clk);
    baud_xn = 1'b1;
    @(negedge clk);
    baud_xn = 1'b0;
  endtask

  task automatic idle(input int k, input int n);
    for (int i = 0; i < n; i++) slot(k, 1'b1);
  endtask

  task automatic send_frame(input int k, input int os, input int nb, input logic [8:0] d,
                            input int pm, input logic pbit, input int ns,
                            input logic [1:0] stopv, input bit corrupt);
    logic [15:0] bits;
    int n;
    bits = '0;
    n = 1;
    for (int i = 0; i < nb; i++) begin bits[n] = d[i]; n++; end
    if (pm != 0) begin bits[n] = pbit; n++; end
    for (int i = 0; i < ns; i++) begin bits[n] = stopv[i]; n++; end
    for (int b = 0; b < n; b++)
      for (int j = 0; j < os; j++)
        slot(k, bits[b] ^ (corrupt && (j == os/2 - 1 + (b % 3))));
  endtask

  initial begin
    total = 0;
    bad = 0;
    reset = 1'b1;
    baud_xn = 1'b0;
    for (int i = 0; i < 3; i++) begin ser[i] = 1'b1; rdy[i] = 1'b1; end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_a", {va, bsa, fea, pea, bka, ova, da}, 32'h0);
    chk("rst_b", {vb, bsb, feb, peb, bkb, ovb, db}, 32'h0);
    chk("rst_c", {vc, bsc, fec, pec, bkc, ovc, dc}, 32'h0);

    // Instance A: 8-N-1 x4
    idle(0, 2);
    expect_ev(0, K_DATA, 9'h0A5);
    send_frame(0, 4, 8, 9'h0A5, 0, 1'b0, 1, 2'b11, 0);
    chk("a5_busy_low", bsa, 1'b0);
    idle(0, 4);
    expect_ev(0, K_FRM, 9'h0);
    send_frame(0, 4, 8, 9'h081, 0, 1'b0, 1, 2'b00, 0);
    idle(0, 4);
    expect_ev(0, K_BRK, 9'h0);
    expect_ev(0, K_DATA, 9'h055);
    for (int i = 0; i < 80; i++) slot(0, 1'b0);
    chk("brk_busy_high", bsa, 1'b1);
    idle(0, 4);
    chk("brk_busy_low", bsa, 1'b0);
    send_frame(0, 4, 8, 9'h055, 0, 1'b0, 1, 2'b11, 0);
    idle(0, 4);
    rdy[0] = 1'b0;
    send_frame(0, 4, 8, 9'h011, 0, 1'b0, 1, 2'b11, 0);
    idle(0, 2);
    chk("hold_valid", va, 1'b1);
    chk("hold_data", da, 8'h11);
    expect_ev(0, K_OVR, 9'h0);
    expect_ev(0, K_DATA, 9'h011);
    send_frame(0, 4, 8, 9'h022, 0, 1'b0, 1, 2'b11, 0);
    idle(0, 2);
    chk("ovr_keep_valid", va, 1'b1);
    chk("ovr_keep_data", da, 8'h11);
    rdy[0] = 1'b1;
    idle(0, 2);
    chk("drain_valid", va, 1'b0);

    // Instance B: 8-E-1 x16
    expect_ev(1, K_DATA, 9'h003);
    send_frame(1, 16, 8, 9'h003, 1, 1'b0, 1, 2'b11, 0);
    idle(1, 4);
    expect_ev(1, K_PAR, 9'h0);
    send_frame(1, 16, 8, 9'h003, 1, 1'b1, 1, 2'b11, 0);
    idle(1, 4);
    chk("par_no_valid", vb, 1'b0);
    slot(1, 1'b0);
    idle(1, 16);
    chk("glitch_busy", bsb, 1'b0);
    expect_ev(1, K_DATA, 9'h05A);
    send_frame(1, 16, 8, 9'h05A, 1, 1'b0, 1, 2'b11, 1);
    idle(1, 4);

    // Instance C: 7-O-2 x4
    rdy[2] = 1'b0;
    send_frame(2, 4, 7, 9'h02B, 2, 1'b1, 2, 2'b11, 0);
    idle(2, 2);
    chk("c_hold_valid", vc, 1'b1);
    chk("c_hold_data", dc, 7'h2B);
    for (int i = 0; i < 16; i++) slot(2, (i < 4) ? 1'b0 : logic'(i[2]));
    chk("c_mid_busy", bsc, 1'b1);
    ser[2] = 1'b1;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("c_midrst", {vc, bsc, fec, pec, bkc, ovc, dc}, 32'h0);
    rdy[2] = 1'b1;
    idle(2, 2);
    expect_ev(2, K_DATA, 9'h03C);
    send_frame(2, 4, 7, 9'h03C, 2, 1'b1, 2, 2'b11, 0);
    idle(2, 4);
    expect_ev(2, K_FRM, 9'h0);
    send_frame(2, 4, 7, 9'h03C, 2, 1'b1, 2, 2'b01, 0);
    idle(2, 4);

    chk("q0_empty", q0.size(), 0);
    chk("q1_empty", q1.size(), 0);
    chk("q2_empty", q2.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_rx_ext.md
# uart_rx_ext

Parametrised serial receiver: the next generation of the fixed 8-N-1, 4× oversampled byte receiver. It is configurable in data width, parity, stop bits and oversampling ratio, and takes 3-sample majority votes per bit. It reports framing, parity, break and overrun events, and presents received words on a valid/ready output with a one-entry holding register. It sits between the pad-side serial input and an RX FIFO or a direct consumer, driven by a shared baud-tick generator.

## Interface
- DATA_BITS, 8, data bits per frame; legal range 5..9.
- PARITY, 0, parity mode: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1, stop bits per frame; 1 or 2.
- OVERSAMPLE, 4, baud ticks per bit; legal range 4..16.
- clk  in  1  system clock. One clock domain.
- reset  in  1  synchronous, active-high reset.
- baud_xn  in  1  one-cycle tick at OVERSAMPLE × baud rate.
- serial  in  1  asynchronous line input; idles high.
- data  out  DATA_BITS  received word, LSB = first bit on the line.
- valid  out  1  `data` holds an unconsumed word.
- ready  in  1  consumer accepts; a transfer happens on a clk edge with valid && ready.
- frame_err  out  1  one-cycle pulse: a stop bit sampled 0 (not a break).
- parity_err  out  1  one-cycle pulse: parity mismatch.
- break_det  out  1  one-cycle pulse: an all-zero frame, stop bits included.
- overrun  out  1  one-cycle pulse: a good word arrived while the holding register was still full.
- busy  out  1  receiver is not in IDLE.

## Operation
- Input passes through a 2-flop synchronizer; both flops reset to 1. All line decisions use `serial_sync`.
- Frame-state machine and phase counter (0..OVERSAMPLE-1) advance only on cycles with baud_xn = 1.
- Bit value is the majority of samples at phases M-1, M and M+1, where M = OVERSAMPLE/2. The decision is made at phase M+1.
- States: IDLE, START, DATA, PARITY, STOP, BRKWAIT.
- IDLE: a tick with serial_sync = 0 enters START. That tick counts as phase 0, so the next phase is 1.
- START: decision 1 → IDLE (false start; no flag, no output). Decision 0 → continue; at phase OVERSAMPLE-1, go to DATA with bit index 0.
- DATA: shift in LSB first. After bit DATA_BITS-1 ends, go to PARITY if PARITY ≠ 0, otherwise STOP.
- PARITY: even mode requires XOR(data, parity bit) = 0; odd mode requires it to be 1.
- STOP: each stop bit gets its own decision.
- Commit happens on the decision tick of the last stop bit. The machine then goes to IDLE immediately, without waiting out the rest of the stop bit.
- Commit priority:
  - break: all data bits, the parity bit (if present) and every stop bit are 0 → break_det pulses, nothing is written, go to BRKWAIT instead of IDLE.
  - frame_err: otherwise, if any stop bit is 0.
  - parity_err: otherwise, on parity mismatch.
  - frame_err and parity_err may pulse together. Any errored frame is discarded.
  - good word: otherwise, the word is written if the holding register is empty or is being drained that same cycle. If it is full and not draining, overrun pulses, the new word is dropped and the held word is kept.
- BRKWAIT: a tick with serial_sync = 1 goes to IDLE.
- Output: `data` is stable while valid = 1. valid clears on transfer unless a commit reloads it in the same cycle.

## Timing
- Reset values: valid = 0, data = 0, every pulse output 0, busy = 0, state IDLE, synchronizer flops = 1.
- A reset mid-frame abandons the frame and produces no flags.
- Latency: valid and data update on the clk edge that registers the commit tick, so they are visible the cycle after that tick.
- The line-to-sync delay is 2 clk.
- Error and overrun pulses last exactly one clk, aligned with that commit edge.
- Simultaneous commit and transfer: the old word transfers, the new word loads, valid stays 1, no overrun.
- baud_xn = 0 cycles change no frame state. Handshake logic runs every cycle.
- busy is high from the START entry edge until the IDLE return edge, including BRKWAIT.

## Test plan
- Defaults (8-N-1, ×4), line carries 0xA5, ready = 1 → one valid cycle with data = 0xA5; no flags; busy is low again within 1 tick of the stop decision.
- PARITY = 1, 0x03 sent with parity bit 0 → data = 0x03. Same byte sent with parity bit 1 → parity_err pulses once, valid stays 0.
- OVERSAMPLE = 16: a 1-tick low glitch is rejected (no busy after START, no valid). A frame with one corrupted sample per bit still yields 0x5A.
- Stop bit driven 0 on 0x81 → frame_err pulses once, no valid. Line held low for 20 bit times → break_det pulses exactly once; after the line goes high, 0x55 is received cleanly.
- ready = 0, frames 0x11 then 0x22 → valid with 0x11, overrun pulses at the second commit; ready = 1 then gives 0x11, and no 0x22 follows.
- STOP_BITS = 2, DATA_BITS = 7, reset asserted in mid-frame → all outputs return to their reset values; the next 0x3C frame is received correctly.
